// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - opcode, width and fetch-state definitions shared by fetch and decode
package instr_fetch_pkg;

    localparam int IW   = 9;
    localparam int OPW  = 4;
    localparam int PC_W = 10;

    localparam logic [OPW-1:0] OP_SHIFT = 4'd0;
    localparam logic [OPW-1:0] OP_BRZ   = 4'd1;
    localparam logic [OPW-1:0] OP_BRN   = 4'd2;
    localparam logic [OPW-1:0] OP_BRU   = 4'd3;
    localparam logic [OPW-1:0] OP_LD    = 4'd4;
    localparam logic [OPW-1:0] OP_ST    = 4'd5;
    localparam logic [OPW-1:0] OP_PUSH  = 4'd6;
    localparam logic [OPW-1:0] OP_POP   = 4'd7;
    localparam logic [OPW-1:0] OP_LDI   = 4'b1110;
    localparam logic [OPW-1:0] OP_DONE  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        IMM  = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_pc_lut.sv
// rtl/instr_fetch_pc_lut.sv - combinational branch-target table, index to absolute PC
module pc_lut #(
    parameter int LUT_W = 5,
    parameter int PC_W  = 10
) (
    input  logic [LUT_W-1:0] i_idx,
    output logic [PC_W-1:0]  o_target
);

    // Unlisted indices fall back to PC 0 so a stray branch restarts the program.
    always_comb begin
        o_target = '0;
        case (i_idx)
            LUT_W'(0):  o_target = PC_W'(0);
            LUT_W'(1):  o_target = PC_W'(8);
            LUT_W'(2):  o_target = PC_W'(16);
            LUT_W'(3):  o_target = PC_W'(40);
            LUT_W'(4):  o_target = PC_W'(100);
            LUT_W'(5):  o_target = PC_W'(200);
            LUT_W'(6):  o_target = PC_W'(512);
            LUT_W'(7):  o_target = PC_W'(777);
            LUT_W'(31): o_target = PC_W'(1020);
            default:    o_target = '0;
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC sequencer feeding the decoder: LDI prefix, LUT branches, halt
module instr_fetch #(
    parameter int PC_W  = 10,
    parameter int IW    = 9,
    parameter int OPW   = 4,
    parameter int LUT_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Branch,
    input  logic             Taken,
    input  logic [IW-1:0]    ImemData,
    output logic [PC_W-1:0]  ImemAddr,
    output logic [IW-1:0]    Instr,
    output logic             InstrValid,
    output logic             ldImmed,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount
);

    import instr_fetch_pkg::fetch_state_t;
    import instr_fetch_pkg::IDLE;
    import instr_fetch_pkg::RUN;
    import instr_fetch_pkg::IMM;
    import instr_fetch_pkg::HALT;
    import instr_fetch_pkg::OP_LDI;
    import instr_fetch_pkg::OP_DONE;

    fetch_state_t     r_state;
    logic [PC_W-1:0]  r_pc;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;

    logic [OPW-1:0]   w_opcode;
    logic [PC_W-1:0]  w_target;
    logic [PC_W-1:0]  w_pc_inc;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_opcode  = ImemData[IW-1 -: OPW];
    assign w_pc_inc  = r_pc + 1'b1;
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    pc_lut #(
        .LUT_W (LUT_W),
        .PC_W  (PC_W)
    ) u_pc_lut (
        .i_idx    (ImemData[LUT_W-1:0]),
        .o_target (w_target)
    );

    // Start outranks everything but Reset: it restarts from any state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else if (Start) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= RUN;
                end
                RUN: begin
                    r_cnt <= w_cnt_inc;
                    if (w_opcode == OP_LDI) begin
                        r_pc    <= w_pc_inc;
                        r_state <= IMM;
                    end else if (w_opcode == OP_DONE) begin
                        r_done  <= 1'b1;
                        r_state <= HALT;
                    end else if (Branch && Taken) begin
                        r_pc <= w_target;
                    end else begin
                        r_pc <= w_pc_inc;
                    end
                end
                IMM: begin
                    r_cnt   <= w_cnt_inc;
                    r_pc    <= w_pc_inc;
                    r_state <= RUN;
                end
                default: begin
                    r_state <= HALT;
                end
            endcase
        end
    end

    assign ImemAddr   = r_pc;
    assign Instr      = ImemData;
    assign InstrValid = (r_state == RUN) || (r_state == IMM);
    assign ldImmed    = (r_state == IMM);
    assign Done       = r_done;
    assign CycleCount = r_cnt;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed-vector bench for instr_fetch
module tb_instr_fetch;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Branch;
    logic        Taken;
    logic [8:0]  ImemData;
    logic [9:0]  ImemAddr;
    logic [8:0]  Instr;
    logic        InstrValid;
    logic        ldImmed;
    logic        Done;
    logic [15:0] CycleCount;

    logic [8:0]  mem [0:1023];
    int          n_vec;
    int          n_miss;

    assign ImemData = mem[ImemAddr];

    instr_fetch dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Branch     (Branch),
        .Taken      (Taken),
        .ImemData   (ImemData),
        .ImemAddr   (ImemAddr),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .ldImmed    (ldImmed),
        .Done       (Done),
        .CycleCount (CycleCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 9'h000;
        Reset  = 1'b1;
        Start  = 1'b1;
        Branch = 1'b0;
        Taken  = 1'b0;
        tick();
        tick();
        chk("rst_addr",  ImemAddr,   0);
        chk("rst_valid", InstrValid, 0);
        chk("rst_ldi",   ldImmed,    0);
        chk("rst_done",  Done,       0);
        chk("rst_cnt",   CycleCount, 0);
        Reset = 1'b0;
        tick();
        chk("idle_addr",  ImemAddr,   0);
        chk("idle_valid", InstrValid, 0);

        // sequential fetch
        Start = 1'b0;
        tick();
        chk("seq_addr0",  ImemAddr,   0);
        chk("seq_valid0", InstrValid, 1);
        chk("seq_cnt0",   CycleCount, 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("seq_addr", ImemAddr,   k);
            chk("seq_cnt",  CycleCount, k);
        end
        Start = 1'b1;
        tick();
        chk("restart_addr",  ImemAddr,   0);
        chk("restart_cnt",   CycleCount, 0);
        chk("restart_valid", InstrValid, 0);

        // LDI prefix: immediate word looks like DONE with LUT index 31, both ignored
        mem[0] = 9'b1110_00000;
        mem[1] = 9'b1111_11111;
        Start = 1'b0;
        tick();
        chk("ldi_addr0", ImemAddr, 0);
        chk("ldi_flag0", ldImmed,  0);
        Branch = 1'b1;
        Taken  = 1'b1;
        tick();
        chk("imm_addr",  ImemAddr,   1);
        chk("imm_flag",  ldImmed,    1);
        chk("imm_valid", InstrValid, 1);
        chk("imm_instr", Instr,      9'h1FF);
        Branch = 1'b0;
        Taken  = 1'b0;
        tick();
        chk("post_imm_addr", ImemAddr, 2);
        chk("post_imm_flag", ldImmed,  0);
        chk("post_imm_done", Done,     0);
        Start = 1'b1;
        tick();
        mem[0] = 9'h000;
        mem[1] = 9'h000;

        // taken branch at PC 5 through lut[3]
        mem[5] = 9'b0001_00011;
        Start = 1'b0;
        tick();
        repeat (5) tick();
        chk("br_at5", ImemAddr, 5);
        Branch = 1'b1;
        Taken  = 1'b1;
        tick();
        chk("br_taken", ImemAddr, 40);
        Branch = 1'b0;
        Taken  = 1'b0;
        Start  = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        repeat (5) tick();
        Branch = 1'b1;
        Taken  = 1'b0;
        tick();
        chk("br_not_taken", ImemAddr, 6);
        Branch = 1'b0;
        Start  = 1'b1;
        tick();
        mem[5] = 9'h000;

        // done opcode at PC 7
        mem[7] = 9'b1111_00000;
        Start = 1'b0;
        tick();
        repeat (7) tick();
        chk("done_at7",  ImemAddr, 7);
        chk("done_pre",  Done,     0);
        tick();
        chk("done_set",   Done,       1);
        chk("halt_valid", InstrValid, 0);
        chk("halt_cnt",   CycleCount, 8);
        Branch = 1'b1;
        Taken  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("halt_addr", ImemAddr, 7);
        end
        chk("halt_done_hold", Done, 1);
        Branch = 1'b0;
        Taken  = 1'b0;
        Start  = 1'b1;
        tick();
        chk("unhalt_addr", ImemAddr, 0);
        chk("unhalt_done", Done,     0);
        mem[7] = 9'h000;

        // PC wrap 1023 -> 0
        Start = 1'b0;
        tick();
        repeat (1023) tick();
        chk("wrap_1023", ImemAddr, 1023);
        tick();
        chk("wrap_0",     ImemAddr,   0);
        chk("wrap_cnt",   CycleCount, 1024);

        // Reset with Start mid-run
        repeat (3) tick();
        Reset = 1'b1;
        Start = 1'b1;
        tick();
        chk("rs_addr",  ImemAddr,   0);
        chk("rs_valid", InstrValid, 0);
        chk("rs_ldi",   ldImmed,    0);
        chk("rs_done",  Done,       0);
        chk("rs_cnt",   CycleCount, 0);
        Reset = 1'b0;
        tick();

        // counter saturation
        Start = 1'b0;
        tick();
        repeat (65534) tick();
        chk("sat_fffe", CycleCount, 16'hFFFE);
        tick();
        chk("sat_ffff", CycleCount, 16'hFFFF);
        repeat (5) tick();
        chk("sat_hold", CycleCount, 16'hFFFF);
        chk("sat_valid", InstrValid, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
